// File: rtl/apb_mslv_pkg.sv
// Shared types for the multi-slave APB master: FSM states, completion codes
// and the slave-index width helper.
package apb_mslv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DERR
    } apb_state_e;

    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_SLV = 2'b01,
        ERR_TMO = 2'b10,
        ERR_DEC = 2'b11
    } apb_err_e;

    function automatic int sel_w(input int num_slv);
        return (num_slv <= 2) ? 1 : $clog2(num_slv);
    endfunction

endpackage

// File: rtl/apb_sel_decode.sv
// Upper-address-bit slave decode: one-hot select plus an out-of-range flag
// for indices that have no slave behind them.
module apb_sel_decode
    import apb_mslv_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int NUM_SLV = 4
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               out_of_range
);

    localparam int SEL_W = sel_w(NUM_SLV);

    logic [SEL_W-1:0] idx;

    always_comb begin
        idx          = addr[ADDR_W-1 -: SEL_W];
        out_of_range = (32'(idx) >= 32'(NUM_SLV));
        sel          = '0;
        for (int unsigned i = 0; i < 32'(NUM_SLV); i++) begin
            if (32'(idx) == i) sel[i] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_mslv.sv
// APB4 master for NUM_SLV slaves: single requests, back-to-back chaining,
// PREADY timeout and decode-error completion with a coded status.
module apb_master_mslv
    import apb_mslv_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                transfer,
    input  logic                write_read,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata_in,
    input  logic [DATA_W/8-1:0] strb_in,
    output logic                req_ready,
    output logic [NUM_SLV-1:0]  PSEL,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR,
    output logic                transfer_done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [DATA_W-1:0]   rdata_out
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    apb_state_e         state;
    apb_err_e           err_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_oor;
    logic               accept;

    apb_sel_decode #(
        .ADDR_W (ADDR_W),
        .NUM_SLV(NUM_SLV)
    ) u_dec (
        .addr        (addr_in),
        .sel         (dec_sel),
        .out_of_range(dec_oor)
    );

    always_comb begin
        req_ready = (state == IDLE) || (state == ACCESS && PREADY) || (state == DERR);
        accept    = transfer && req_ready;
        err_code  = err_q;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state         <= IDLE;
            PSEL          <= '0;
            PENABLE       <= 1'b0;
            PADDR         <= '0;
            PWRITE        <= 1'b0;
            PWDATA        <= '0;
            PSTRB         <= '0;
            transfer_done <= 1'b0;
            error         <= 1'b0;
            err_q         <= ERR_OK;
            rdata_out     <= '0;
            wait_cnt      <= '0;
        end else begin
            transfer_done <= 1'b0;
            error         <= 1'b0;
            case (state)
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        transfer_done <= 1'b1;
                        error         <= PSLVERR;
                        err_q         <= PSLVERR ? ERR_SLV : ERR_OK;
                        if (!PWRITE) rdata_out <= PRDATA;
                        state   <= IDLE;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                    end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                        transfer_done <= 1'b1;
                        error         <= 1'b1;
                        err_q         <= ERR_TMO;
                        state   <= IDLE;
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DERR: begin
                    transfer_done <= 1'b1;
                    error         <= 1'b1;
                    err_q         <= ERR_DEC;
                    state         <= IDLE;
                end
                default: ;
            endcase
            // A new request overrides the IDLE return chosen above, giving back-to-back chaining.
            if (accept) begin
                PADDR    <= addr_in;
                PWRITE   <= write_read;
                PWDATA   <= wdata_in;
                PSTRB    <= write_read ? strb_in : '0;
                PENABLE  <= 1'b0;
                wait_cnt <= '0;
                if (dec_oor) begin
                    state <= DERR;
                    PSEL  <= '0;
                end else begin
                    state <= SETUP;
                    PSEL  <= dec_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_mslv.sv
// Bench for apb_master_mslv (3 slaves, timeout 16): vector table, back-to-back
// and reset sequences, then random transfers against a transaction-level model.
module tb_apb_master_mslv;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer;
    logic        write_read;
    logic [7:0]  addr_in;
    logic [31:0] wdata_in;
    logic [3:0]  strb_in;
    logic        req_ready;
    logic [2:0]  PSEL;
    logic        PENABLE;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        transfer_done;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] rdata_out;

    apb_master_mslv #(
        .ADDR_W (8),
        .DATA_W (32),
        .NUM_SLV(3),
        .TIMEOUT(16)
    ) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .transfer     (transfer),
        .write_read   (write_read),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .strb_in      (strb_in),
        .req_ready    (req_ready),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PADDR        (PADDR),
        .PWRITE       (PWRITE),
        .PWDATA       (PWDATA),
        .PSTRB        (PSTRB),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .transfer_done(transfer_done),
        .error        (error),
        .err_code     (err_code),
        .rdata_out    (rdata_out)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  st;
        int          waits;
        logic        slverr;
        logic [31:0] prd;
        logic [2:0]  e_psel;
        int          e_lat;
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t        tbl[8];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mrd;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Drives one request, plays a slave that raises PREADY after v.waits
    // ACCESS cycles, and checks bus and completion against the vector.
    task automatic run_xfer(input string nm, input vec_t v);
        int lat;
        int acc;
        bit done;
        transfer   = 1'b1;
        write_read = v.w;
        addr_in    = v.a;
        wdata_in   = v.wd;
        strb_in    = v.st;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;
        check({nm, ".req_ready"}, req_ready, 1);
        tick();
        transfer = 1'b0;
        check({nm, ".psel0"}, PSEL, v.e_psel);
        check({nm, ".penable0"}, PENABLE, 0);
        check({nm, ".paddr"}, PADDR, v.a);
        check({nm, ".pwrite"}, PWRITE, v.w);
        check({nm, ".pwdata"}, PWDATA, v.wd);
        check({nm, ".pstrb"}, PSTRB, v.w ? v.st : 4'h0);
        lat  = 0;
        acc  = 0;
        done = 0;
        while (!done && lat < 40) begin
            PREADY  = PENABLE && (acc == v.waits);
            PSLVERR = PREADY && v.slverr;
            PRDATA  = PREADY ? v.prd : $urandom();
            if (PENABLE) acc++;
            tick();
            lat++;
            if (transfer_done) done = 1;
            else begin
                check({nm, ".psel_hold"}, PSEL, v.e_psel);
                check({nm, ".penable_acc"}, PENABLE, v.e_psel != 0);
            end
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        check({nm, ".latency"}, lat, v.e_lat);
        check({nm, ".err_code"}, err_code, v.e_err);
        check({nm, ".error"}, error, v.e_err != 0);
        check({nm, ".rdata"}, rdata_out, v.e_rdata);
        check({nm, ".psel_end"}, PSEL, 0);
        check({nm, ".penable_end"}, PENABLE, 0);
        tick();
        check({nm, ".done_pulse"}, transfer_done, 0);
        check({nm, ".error_pulse"}, error, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] bb_psel[7];
        logic       bb_pen[7];
        logic       bb_done[7];
        logic [7:0] bb_addr[7];

        tbl[0] = '{1'b1, 8'h45, 32'hDEADBEEF, 4'hF, 0,  1'b0, 32'h0,        3'b010, 2,  2'd0, 32'h0};
        tbl[1] = '{1'b0, 8'h80, 32'h11111111, 4'hF, 3,  1'b0, 32'h12345678, 3'b100, 5,  2'd0, 32'h12345678};
        tbl[2] = '{1'b0, 8'hC0, 32'h0,        4'h0, 0,  1'b0, 32'h55555555, 3'b000, 1,  2'd3, 32'h12345678};
        tbl[3] = '{1'b1, 8'h01, 32'h01020304, 4'hF, 16, 1'b0, 32'h0,        3'b001, 17, 2'd2, 32'h12345678};
        tbl[4] = '{1'b1, 8'h02, 32'h0A0B0C0D, 4'h5, 15, 1'b0, 32'h0,        3'b001, 17, 2'd0, 32'h12345678};
        tbl[5] = '{1'b0, 8'h7F, 32'h0,        4'hF, 1,  1'b1, 32'hCAFEF00D, 3'b010, 3,  2'd1, 32'hCAFEF00D};
        tbl[6] = '{1'b1, 8'hBF, 32'h99887766, 4'h3, 0,  1'b1, 32'h0,        3'b100, 2,  2'd1, 32'hCAFEF00D};
        tbl[7] = '{1'b0, 8'h40, 32'h0,        4'hF, 2,  1'b0, 32'hA5A50001, 3'b010, 4,  2'd0, 32'hA5A50001};

        bb_psel = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000};
        bb_pen  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bb_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bb_addr = '{8'h10, 8'h10, 8'h50, 8'h50, 8'h90, 8'h90, 8'h90};

        PRESET     = 1'b1;
        transfer   = 1'b0;
        write_read = 1'b0;
        addr_in    = '0;
        wdata_in   = '0;
        strb_in    = '0;
        PRDATA     = '0;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;
        #12;
        check("rst.psel", PSEL, 0);
        check("rst.penable", PENABLE, 0);
        check("rst.paddr", PADDR, 0);
        check("rst.pwdata", PWDATA, 0);
        check("rst.pstrb", PSTRB, 0);
        check("rst.done", transfer_done, 0);
        check("rst.err_code", err_code, 0);
        check("rst.rdata", rdata_out, 0);
        check("rst.req_ready", req_ready, 1);
        @(negedge PCLK);
        PRESET = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_xfer($sformatf("vec%0d", i), tbl[i]);

        // Three chained writes with transfer held high.
        PREADY     = 1'b1;
        PSLVERR    = 1'b0;
        PRDATA     = '0;
        transfer   = 1'b1;
        write_read = 1'b1;
        addr_in    = 8'h10;
        wdata_in   = 32'h0000AAAA;
        strb_in    = 4'hF;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("b2b%0d.psel", k), PSEL, bb_psel[k]);
            check($sformatf("b2b%0d.penable", k), PENABLE, bb_pen[k]);
            check($sformatf("b2b%0d.done", k), transfer_done, bb_done[k]);
            check($sformatf("b2b%0d.paddr", k), PADDR, bb_addr[k]);
            if (k == 0) begin addr_in = 8'h50; wdata_in = 32'h0000BBBB; end
            if (k == 2) begin addr_in = 8'h90; wdata_in = 32'h0000CCCC; end
            if (k == 4) transfer = 1'b0;
        end
        PREADY = 1'b0;
        check("b2b.err_code", err_code, 0);
        check("b2b.rdata", rdata_out, 32'hA5A50001);
        tick();

        // Random transfers; expectations from the transaction-level rules.
        mrd = 32'hA5A50001;
        for (int r = 0; r < 30; r++) begin
            vec_t v;
            int   idx;
            v.w      = 1'($urandom());
            v.a      = 8'($urandom());
            v.wd     = $urandom();
            v.st     = 4'($urandom());
            v.waits  = ($urandom_range(0, 9) == 0) ? 16 + int'($urandom_range(0, 3))
                                                   : int'($urandom_range(0, 4));
            v.slverr = ($urandom_range(0, 3) == 0);
            v.prd    = $urandom();
            idx      = int'(v.a) / 64;
            if (idx >= 3) begin
                v.e_psel = 3'b000;
                v.e_lat  = 1;
                v.e_err  = 2'd3;
            end else begin
                v.e_psel = 3'(1 << idx);
                if (v.waits >= 16) begin
                    v.e_lat = 17;
                    v.e_err = 2'd2;
                end else begin
                    v.e_lat = v.waits + 2;
                    v.e_err = v.slverr ? 2'd1 : 2'd0;
                    if (!v.w) mrd = v.prd;
                end
            end
            v.e_rdata = mrd;
            run_xfer($sformatf("rnd%0d", r), v);
        end

        // Reset asserted in the middle of ACCESS.
        transfer   = 1'b1;
        write_read = 1'b0;
        addr_in    = 8'h80;
        PREADY     = 1'b0;
        tick();
        transfer = 1'b0;
        tick();
        tick();
        check("mid.penable_pre", PENABLE, 1);
        #2 PRESET = 1'b1;
        #1;
        check("mid.psel", PSEL, 0);
        check("mid.penable", PENABLE, 0);
        check("mid.paddr", PADDR, 0);
        check("mid.pstrb", PSTRB, 0);
        check("mid.done", transfer_done, 0);
        check("mid.err_code", err_code, 0);
        check("mid.rdata", rdata_out, 0);
        tick();
        check("mid.done_hold", transfer_done, 0);
        PRESET = 1'b0;
        tick();
        check("mid.done_after", transfer_done, 0);
        run_xfer("post_rst", '{1'b1, 8'h00, 32'h13579BDF, 4'hC, 0, 1'b0, 32'h0, 3'b001, 2, 2'd0, 32'h0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_mslv.md
Name: apb_master_mslv

Overview:
Parametrised APB4 master: accepts single read/write requests from a local command port and runs SETUP/ACCESS phases on an APB bus shared by NUM_SLV slaves. Successor to the single-slave, fixed-width master. Adds width parameters, one-hot PSEL decode from the upper address bits, a PREADY wait timeout, decode-error handling, back-to-back transfers and a coded error status. Sits between the testbench/CPU-side request logic and the APB slave fabric.

Parameters:
ADDR_W, 8, address width (PADDR, addr_in)
DATA_W, 32, data width (must be 8, 16 or 32)
NUM_SLV, 4, number of slaves (1..16); SEL_W = max(1, clog2(NUM_SLV))
TIMEOUT, 16, ACCESS wait cycles before abort; 0 disables timeout

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
transfer  in  1  request valid
write_read  in  1  1 = write, 0 = read
addr_in  in  ADDR_W  request address; slave index = addr_in[ADDR_W-1 -: SEL_W]
wdata_in  in  DATA_W  write data
strb_in  in  DATA_W/8  write byte strobes
req_ready  out  1  request accepted when transfer && req_ready at posedge
PSEL  out  NUM_SLV  one-hot slave select
PENABLE  out  1  access phase
PADDR  out  ADDR_W  bus address
PWRITE  out  1  bus direction
PWDATA  out  DATA_W  bus write data
PSTRB  out  DATA_W/8  bus strobes (forced 0 on reads)
PRDATA  in  DATA_W  read data from the selected slave
PREADY  in  1  slave ready
PSLVERR  in  1  slave error, valid with PREADY
transfer_done  out  1  one-cycle completion pulse
error  out  1  high with transfer_done when err_code != 0
err_code  out  2  00 OK, 01 PSLVERR, 10 timeout, 11 decode
rdata_out  out  DATA_W  captured PRDATA, held until the next read completes

Behaviour:
- Reset (async, PRESET=1): state IDLE; PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, transfer_done=0, error=0, err_code=00, rdata_out=0, timeout counter=0. Reset asserted mid-transfer aborts immediately; no completion pulse is issued.
- States: IDLE, SETUP, ACCESS, DERR.
- req_ready (combinational) = (state==IDLE) || (state==ACCESS && PREADY) || (state==DERR).
- Acceptance edge: addr, direction, data and strobes are registered onto the PADDR/PWRITE/PWDATA/PSTRB outputs. If slave index < NUM_SLV, go to SETUP; otherwise go to DERR.
- SETUP, one cycle: PSEL[idx]=1, PENABLE=0. Next state is ACCESS.
- ACCESS: PSEL held, PENABLE=1. PADDR/PWRITE/PWDATA/PSTRB stay stable from SETUP through ACCESS.
- ACCESS with PREADY sampled 1:
  - Next cycle: transfer_done=1.
  - err_code = PSLVERR ? 01 : 00.
  - rdata_out <= PRDATA for reads, including reads that complete with PSLVERR.
  - If transfer is also high, accept the new request: next state SETUP (or DERR), with PSEL re-decoded and PENABLE=0. Otherwise go to IDLE with PSEL=0.
- ACCESS with PREADY=0: counter increments. If TIMEOUT!=0 and counter reaches TIMEOUT-1 while PREADY=0, abort: next cycle PSEL=0, PENABLE=0, transfer_done=1, err_code=10, state IDLE. The counter clears on entering SETUP.
- DERR, one cycle: no PSEL asserted, transfer_done=1, err_code=11, rdata_out unchanged. A request accepted in DERR goes straight to SETUP/DERR.
- Output timing: transfer_done, error, err_code are registered. err_code holds its value until the next completion. transfer_done is never high for two consecutive cycles except back-to-back completions, which require at least 2 cycles each.
- Minimum transfer: 3 cycles from acceptance to transfer_done (SETUP, ACCESS with PREADY=1, done).
- Reads: PSTRB=0 and PWDATA is driven with the captured wdata_in (don't-care to slaves).
- transfer while req_ready=0 is ignored; the requester must hold it.

Decomposition:
- Shared package apb_mslv_pkg:
  - state enum (IDLE, SETUP, ACCESS, DERR)
  - err_code enum (ERR_OK, ERR_SLV, ERR_TMO, ERR_DEC)
  - SEL_W function
- Sub-module apb_sel_decode: combinational addr -> one-hot PSEL plus out-of-range flag, parametrised by ADDR_W/NUM_SLV.
- Timeout counter is inline.

Test Plan:
- Write addr 0x45, data 0xDEADBEEF, strb 0xF, PREADY=1 immediately -> PSEL=0010 (slave 1) for 2 cycles, PENABLE in 2nd, PSTRB=F; transfer_done 3 cycles after acceptance, err_code=00.
- Read addr 0x80, PREADY low 3 cycles, PRDATA=0x12345678 -> ACCESS lasts 4 cycles; rdata_out=0x12345678, PSTRB=0, err_code=00.
- NUM_SLV=3, addr 0xC0 -> no PSEL bit ever high; transfer_done next-next cycle, err_code=11, error=1.
- TIMEOUT=16, PREADY held 0 -> abort after 16 ACCESS cycles; PSEL drops, err_code=10; following request proceeds normally.
- Back-to-back: transfer held high with 3 writes, PREADY=1 -> PSEL remains asserted, PENABLE toggles 0/1, three done pulses 2 cycles apart. Read with PSLVERR=1 -> err_code=01, rdata_out updated.
- PRESET pulsed during ACCESS -> all outputs 0 asynchronously; no transfer_done; next request starts from IDLE.
